// File: rtl/fmul_result_buf.sv
// Result buffer behind the FP multiplier: classifies each op into {nan,inf,ovf,unf},
// queues {product, flags} in a FWFT FIFO, keeps sticky flags. FMUL_FLAG_SAT_EN saturates stored products.
module fmul_result_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP        = 8,
  parameter int MANT       = 23,
  parameter int BIAS       = 127,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [3:0]            out_flags_o,
  input  logic                  clr_i,
  output logic [3:0]            sticky_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [EXP+1:0] BIAS_W = (EXP+2)'(BIAS);
  localparam logic signed [EXP+1:0] OVF_TH = (EXP+2)'((1 << EXP) - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            flags;
  } ent_t;

  ent_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;

  // field extraction
  logic [EXP-1:0]  ea, eb, ec;
  logic [MANT-1:0] ma, mb;
  logic            sg;
  assign ea = a_i[DATA_WIDTH-2 -: EXP];
  assign eb = b_i[DATA_WIDTH-2 -: EXP];
  assign ec = c_i[DATA_WIDTH-2 -: EXP];
  assign ma = a_i[MANT-1:0];
  assign mb = b_i[MANT-1:0];
  assign sg = a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1];

  logic signed [EXP+1:0] s;
  assign s = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_W;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic f_nan, f_inf, f_zero, f_ovf, f_unf;
  assign a_nan  = (&ea) && (ma != '0);
  assign b_nan  = (&eb) && (mb != '0);
  assign a_inf  = (&ea) && (ma == '0);
  assign b_inf  = (&eb) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  // inf*0 is invalid, so it ranks as nan ahead of the plain inf case
  assign f_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign f_inf  = !f_nan && (a_inf || b_inf);
  assign f_zero = !f_nan && !f_inf && (a_zero || b_zero);
  assign f_ovf  = !f_nan && !f_inf && !f_zero && ((s >= OVF_TH) || (&ec));
  assign f_unf  = !f_nan && !f_inf && !f_zero && !f_ovf && (s <= 0);

  logic [3:0]            flags;
  logic [DATA_WIDTH-1:0] store_data;
  assign flags = {f_nan, f_inf, f_ovf, f_unf};

`ifdef FMUL_FLAG_SAT_EN
  always_comb begin
    store_data = c_i;
    if (f_nan)
      store_data = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
    else if (f_inf || f_ovf)
      store_data = {sg, {EXP{1'b1}}, {MANT{1'b0}}};
    else if (f_zero || f_unf)
      store_data = {sg, {(EXP+MANT){1'b0}}};
  end
`else
  assign store_data = c_i;
`endif

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && !full;
  assign pop         = !empty && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sticky_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clr_i)     sticky_o <= push ? flags : 4'b0000;
      else if (push) sticky_o <= sticky_o | flags;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{data: store_data, flags: flags};
  end

  assign out_data_o  = empty ? '0 : mem[rd_ptr].data;
  assign out_flags_o = empty ? '0 : mem[rd_ptr].flags;

endmodule
